// File: rtl/rob_queue.sv
// In-order-retire reorder buffer: allocate at tail, complete out of order by tag, commit from head.
// Optional synchronous flush of all entries is compiled in with ROB_FLUSH_EN.
module rob_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_regwrite,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    input  logic [DATA_W-1:0] cmpl_data,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_rd,
    output logic              commit_regwrite,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
`ifdef ROB_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  rw_mem;
    logic [REG_W-1:0]  rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    cnt;
    logic              alloc_fire;
    logic              cmpl_fire;
    logic              commit_fire;

    assign full         = (cnt == (TAG_W+1)'(DEPTH));
    assign empty        = (cnt == '0);
    assign count        = cnt;
    assign alloc_ready  = ~full;
    assign alloc_tag    = tail;
    assign commit_tag   = head;
    assign commit_valid = busy[head] & done[head];

    assign alloc_fire  = alloc_valid & ~full;
    assign cmpl_fire   = cmpl_valid & busy[cmpl_tag] & ~done[cmpl_tag];
    assign commit_fire = commit_valid & commit_ready;

    always_comb begin
        commit_rd       = '0;
        commit_regwrite = 1'b0;
        commit_data     = '0;
        if (commit_valid) begin
            commit_rd       = rd_mem[head];
            commit_regwrite = rw_mem[head];
            commit_data     = data_mem[head];
        end
    end

    // Alloc, completion and commit never target the same entry in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            busy <= '0;
            done <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            busy <= '0;
            done <= '0;
        end
`endif
        else begin
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + TAG_W'(1);
            end
            if (cmpl_fire) begin
                done[cmpl_tag] <= 1'b1;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + TAG_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   cnt <= cnt + (TAG_W+1)'(1);
                2'b01:   cnt <= cnt - (TAG_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is not reset; it is only visible through a busy and done entry.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail] <= alloc_rd;
            rw_mem[tail] <= alloc_regwrite;
        end
        if (cmpl_fire) begin
            data_mem[cmpl_tag] <= cmpl_data;
        end
    end

endmodule
